// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB front-end of the UART: register offsets,
// core register-select codes, slave FSM states and decoded request kinds.
package apb_uart_pkg;

  localparam logic [4:0] BAUD_OFS   = 5'h00;
  localparam logic [4:0] FRAME_OFS  = 5'h04;
  localparam logic [4:0] PARITY_OFS = 5'h08;
  localparam logic [4:0] STOP_OFS   = 5'h0C;
  localparam logic [4:0] TXD_OFS    = 5'h10;
  localparam logic [4:0] RXD_OFS    = 5'h14;

  localparam int unsigned CFG_BAUD   = 0;
  localparam int unsigned CFG_FRAME  = 1;
  localparam int unsigned CFG_PARITY = 2;
  localparam int unsigned CFG_STOP   = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_ERR, DONE} slv_state_t;

  typedef enum logic [2:0] {REQ_CFG_WR, REQ_CFG_RD, REQ_TX, REQ_RX, REQ_BAD} req_kind_t;

endpackage

// File: rtl/apb_uart_addr_decode.sv
// Combinational APB address/direction decode into a UART request kind and
// the core register select; anything unmapped or wrong-direction is REQ_BAD.
module apb_uart_addr_decode
  import apb_uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CORE_ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0]      PADDR,
  input  logic                       PWRITE,
  output req_kind_t                  req_kind,
  output logic [CORE_ADDR_WIDTH-1:0] config_address
);

  logic upper_zero;
  assign upper_zero = (PADDR[ADDR_WIDTH-1:5] == '0);

  always_comb begin
    req_kind       = REQ_BAD;
    config_address = '0;
    if (upper_zero) begin
      case (PADDR[4:0])
        BAUD_OFS: begin
          req_kind       = PWRITE ? REQ_CFG_WR : REQ_CFG_RD;
          config_address = CORE_ADDR_WIDTH'(CFG_BAUD);
        end
        FRAME_OFS: begin
          req_kind       = PWRITE ? REQ_CFG_WR : REQ_CFG_RD;
          config_address = CORE_ADDR_WIDTH'(CFG_FRAME);
        end
        PARITY_OFS: begin
          req_kind       = PWRITE ? REQ_CFG_WR : REQ_CFG_RD;
          config_address = CORE_ADDR_WIDTH'(CFG_PARITY);
        end
        STOP_OFS: begin
          req_kind       = PWRITE ? REQ_CFG_WR : REQ_CFG_RD;
          config_address = CORE_ADDR_WIDTH'(CFG_STOP);
        end
        TXD_OFS:  if (PWRITE)  req_kind = REQ_TX;
        RXD_OFS:  if (!PWRITE) req_kind = REQ_RX;
        default:  req_kind = REQ_BAD;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_slave_if.sv
// APB3 slave front-end for the UART core: turns APB transfers into one-hot
// core request strobes and returns PREADY/PRDATA/PSLVERR. Optional ACCESS
// timeout is enabled with `define APB_UART_TIMEOUT_EN.
module apb_uart_slave_if
  import apb_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CORE_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_WIDTH-1:0]      PADDR,
  input  logic [DATA_WIDTH-1:0]      PWDATA,
  output logic [DATA_WIDTH-1:0]      PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [DATA_WIDTH-1:0]      write_data_in,
  output logic [CORE_ADDR_WIDTH-1:0] config_address,
  output logic                       TX_detect,
  output logic                       RX_detect,
  output logic                       config_write_detect,
  output logic                       config_read_detect,
  input  logic [DATA_WIDTH-1:0]      read_data,
  input  logic                       ready,
  input  logic                       error
);

  slv_state_t                 state;
  req_kind_t                  dec_kind;
  logic [CORE_ADDR_WIDTH-1:0] dec_addr;
  logic                       is_read;
  logic                       first_acc;

  apb_uart_addr_decode #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .CORE_ADDR_WIDTH (CORE_ADDR_WIDTH)
  ) u_decode (
    .PADDR          (PADDR),
    .PWRITE         (PWRITE),
    .req_kind       (dec_kind),
    .config_address (dec_addr)
  );

`ifdef APB_UART_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state               <= IDLE;
      is_read             <= 1'b0;
      first_acc           <= 1'b0;
      PRDATA              <= '0;
      PREADY              <= 1'b0;
      PSLVERR             <= 1'b0;
      write_data_in       <= '0;
      config_address      <= '0;
      TX_detect           <= 1'b0;
      RX_detect           <= 1'b0;
      config_write_detect <= 1'b0;
      config_read_detect  <= 1'b0;
`ifdef APB_UART_TIMEOUT_EN
      tmo_cnt             <= '0;
`endif
    end else begin
      PREADY <= 1'b0;
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            write_data_in  <= PWDATA;
            config_address <= dec_addr;
            is_read        <= !PWRITE;
            PRDATA         <= '0;
            first_acc      <= 1'b1;
            if (dec_kind == REQ_BAD) begin
              PSLVERR <= 1'b1;
              PREADY  <= 1'b1;
              state   <= DONE;
            end else begin
              PSLVERR             <= 1'b0;
              config_write_detect <= (dec_kind == REQ_CFG_WR);
              config_read_detect  <= (dec_kind == REQ_CFG_RD);
              TX_detect           <= (dec_kind == REQ_TX);
              RX_detect           <= (dec_kind == REQ_RX);
`ifdef APB_UART_TIMEOUT_EN
              tmo_cnt             <= '0;
`endif
              state               <= ACCESS;
            end
          end
        end
        ACCESS: begin
          first_acc <= 1'b0;
          // ready in the first ACCESS cycle may be left over from the previous op
          if (!first_acc && ready) begin
            if (is_read) PRDATA <= read_data;
            TX_detect           <= 1'b0;
            RX_detect           <= 1'b0;
            config_write_detect <= 1'b0;
            config_read_detect  <= 1'b0;
            state               <= WAIT_ERR;
          end
`ifdef APB_UART_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            TX_detect           <= 1'b0;
            RX_detect           <= 1'b0;
            config_write_detect <= 1'b0;
            config_read_detect  <= 1'b0;
            PRDATA              <= '0;
            PSLVERR             <= 1'b1;
            PREADY              <= 1'b1;
            state               <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        WAIT_ERR: begin
          PSLVERR <= error;
          PREADY  <= 1'b1;
          if (error) PRDATA <= '0;
          state   <= DONE;
        end
        DONE: begin
          PSLVERR <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_slave_if.sv
// Directed self-checking bench for apb_uart_slave_if; the timeout scenario
// runs only when APB_UART_TIMEOUT_EN is defined.
module tb_apb_uart_slave_if;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned CAW = 4;
  localparam int unsigned TMO = 16;

  logic           PCLK = 1'b0;
  logic           PRESET = 1'b1;
  logic           PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0]  PADDR = '0;
  logic [DW-1:0]  PWDATA = '0;
  logic [DW-1:0]  PRDATA;
  logic           PREADY, PSLVERR;
  logic [DW-1:0]  write_data_in;
  logic [CAW-1:0] config_address;
  logic           TX_detect, RX_detect, config_write_detect, config_read_detect;
  logic [DW-1:0]  read_data = '0;
  logic           ready = 1'b0, error = 1'b0;
  logic [3:0]     strb;

  int n_cmp = 0;
  int n_bad = 0;

  assign strb = {config_write_detect, config_read_detect, TX_detect, RX_detect};

  always #5 PCLK = ~PCLK;

  apb_uart_slave_if #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .CORE_ADDR_WIDTH (CAW),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .PCLK                (PCLK),
    .PRESET              (PRESET),
    .PSEL                (PSEL),
    .PENABLE             (PENABLE),
    .PWRITE              (PWRITE),
    .PADDR               (PADDR),
    .PWDATA              (PWDATA),
    .PRDATA              (PRDATA),
    .PREADY              (PREADY),
    .PSLVERR             (PSLVERR),
    .write_data_in       (write_data_in),
    .config_address      (config_address),
    .TX_detect           (TX_detect),
    .RX_detect           (RX_detect),
    .config_write_detect (config_write_detect),
    .config_read_detect  (config_read_detect),
    .read_data           (read_data),
    .ready               (ready),
    .error               (error)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Setup phase, then move into the access phase right after the setup edge.
  task automatic apb_setup(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    tick();
    PENABLE = 1'b1;
  endtask

  task automatic apb_end();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (strb !== 4'b0000) begin n_bad++; $display("FAIL reset_strb got %b want 0000", strb); end
    n_cmp++; if ({PREADY, PSLVERR} !== 2'b00) begin n_bad++; $display("FAIL reset_resp got %b want 00", {PREADY, PSLVERR}); end
    n_cmp++; if (PRDATA !== '0 || write_data_in !== '0 || config_address !== '0) begin
      n_bad++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", PRDATA, write_data_in, config_address);
    end
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_cfg_write();
    ready = 1'b0; error = 1'b0;
    apb_setup(1'b1, 32'h04, 32'h7);
    n_cmp++; if (strb !== 4'b1000) begin n_bad++; $display("FAIL cfgwr_strb got %b want 1000", strb); end
    n_cmp++; if (config_address !== 4'd1) begin n_bad++; $display("FAIL cfgwr_addr got %0d want 1", config_address); end
    n_cmp++; if (write_data_in !== 32'h7) begin n_bad++; $display("FAIL cfgwr_wdata got %h want 7", write_data_in); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (strb !== 4'b1000 || PREADY !== 1'b0) begin
        n_bad++; $display("FAIL cfgwr_hold%0d got strb=%b pready=%b want 1000/0", i, strb, PREADY);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++; if (strb !== 4'b0000 || PREADY !== 1'b0) begin
      n_bad++; $display("FAIL cfgwr_drop got strb=%b pready=%b want 0000/0", strb, PREADY);
    end
    tick();
    n_cmp++; if ({PREADY, PSLVERR} !== 2'b10) begin n_bad++; $display("FAIL cfgwr_resp got %b want 10", {PREADY, PSLVERR}); end
    n_cmp++; if (PRDATA !== '0) begin n_bad++; $display("FAIL cfgwr_prdata got %h want 0", PRDATA); end
    apb_end();
    tick();
    n_cmp++; if (PREADY !== 1'b0) begin n_bad++; $display("FAIL cfgwr_pulse got %b want 0", PREADY); end
  endtask

  // ready is already high at setup; it must be ignored in the first ACCESS cycle.
  task automatic test_cfg_read();
    ready = 1'b1; read_data = 32'd9600;
    apb_setup(1'b0, 32'h00, 32'h0);
    n_cmp++; if (strb !== 4'b0100 || config_address !== 4'd0) begin
      n_bad++; $display("FAIL cfgrd_strb got %b/%0d want 0100/0", strb, config_address);
    end
    tick();
    n_cmp++; if (strb !== 4'b0100) begin n_bad++; $display("FAIL cfgrd_hold got %b want 0100", strb); end
    tick();
    ready = 1'b0;
    n_cmp++; if (strb !== 4'b0000) begin n_bad++; $display("FAIL cfgrd_drop got %b want 0000", strb); end
    tick();
    n_cmp++; if ({PREADY, PSLVERR} !== 2'b10) begin n_bad++; $display("FAIL cfgrd_resp got %b want 10", {PREADY, PSLVERR}); end
    n_cmp++; if (PRDATA !== 32'h2580) begin n_bad++; $display("FAIL cfgrd_prdata got %h want 00002580", PRDATA); end
    apb_end();
    tick();
  endtask

  task automatic test_decode_err();
    logic          wr_t   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] addr_t [6] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h06, 32'h20};
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apb_setup(wr_t[i], addr_t[i], 32'hDEAD_BEEF);
      n_cmp++; if (strb !== 4'b0000) begin n_bad++; $display("FAIL decerr%0d_strb got %b want 0000", i, strb); end
      n_cmp++; if ({PREADY, PSLVERR} !== 2'b11) begin n_bad++; $display("FAIL decerr%0d_resp got %b want 11", i, {PREADY, PSLVERR}); end
      n_cmp++; if (PRDATA !== '0) begin n_bad++; $display("FAIL decerr%0d_prdata got %h want 0", i, PRDATA); end
      apb_end();
      tick();
      n_cmp++; if ({PREADY, strb} !== 5'b0) begin n_bad++; $display("FAIL decerr%0d_after got %b want 00000", i, {PREADY, strb}); end
    end
  endtask

  task automatic test_tx_error();
    ready = 1'b0; error = 1'b0;
    apb_setup(1'b1, 32'h10, 32'hA5);
    n_cmp++; if (strb !== 4'b0010 || write_data_in !== 32'hA5) begin
      n_bad++; $display("FAIL tx_strb got %b/%h want 0010/a5", strb, write_data_in);
    end
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0; error = 1'b1;
    n_cmp++; if (strb !== 4'b0000) begin n_bad++; $display("FAIL tx_drop got %b want 0000", strb); end
    tick();
    error = 1'b0;
    n_cmp++; if ({PREADY, PSLVERR} !== 2'b11) begin n_bad++; $display("FAIL tx_resp got %b want 11", {PREADY, PSLVERR}); end
    n_cmp++; if (PRDATA !== '0) begin n_bad++; $display("FAIL tx_prdata got %h want 0", PRDATA); end
    apb_end();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd_t [2] = '{32'h11, 32'h22};
    ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      read_data = rd_t[k];
      apb_setup(1'b0, 32'h14, 32'h0);
      n_cmp++; if (strb !== 4'b0001) begin n_bad++; $display("FAIL b2b%0d_strb got %b want 0001", k, strb); end
      tick();
      n_cmp++; if (strb !== 4'b0001) begin n_bad++; $display("FAIL b2b%0d_hold got %b want 0001", k, strb); end
      tick();
      n_cmp++; if (strb !== 4'b0000) begin n_bad++; $display("FAIL b2b%0d_drop got %b want 0000", k, strb); end
      tick();
      n_cmp++; if ({PREADY, PSLVERR} !== 2'b10 || PRDATA !== rd_t[k]) begin
        n_bad++; $display("FAIL b2b%0d_resp got %b/%h want 10/%h", k, {PREADY, PSLVERR}, PRDATA, rd_t[k]);
      end
      tick();
    end
    apb_end();
    ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    ready = 1'b0;
    apb_setup(1'b1, 32'h08, 32'h3C);
    tick();
    n_cmp++; if (strb !== 4'b1000 || config_address !== 4'd2) begin
      n_bad++; $display("FAIL rstmid_pre got %b/%0d want 1000/2", strb, config_address);
    end
    #2 PRESET = 1'b1;
    #1;
    n_cmp++; if (strb !== 4'b0000 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_resp got %b/%b/%b want 0000/0/0", strb, PREADY, PSLVERR);
    end
    n_cmp++; if (write_data_in !== '0 || config_address !== '0 || PRDATA !== '0) begin
      n_bad++; $display("FAIL rstmid_data got %h/%h/%h want 0/0/0", write_data_in, config_address, PRDATA);
    end
    apb_end();
    tick();
    PRESET = 1'b0;
    tick();
  endtask

`ifdef APB_UART_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    ready = 1'b0;
    held  = 0;
    apb_setup(1'b0, 32'h0C, 32'h0);
    for (int i = 0; i < 40 && strb == 4'b0100; i++) begin
      held++;
      tick();
    end
    n_cmp++; if (held !== 16) begin n_bad++; $display("FAIL tmo_cycles got %0d want 16", held); end
    n_cmp++; if ({strb, PREADY, PSLVERR} !== 6'b000011) begin
      n_bad++; $display("FAIL tmo_resp got %b want 000011", {strb, PREADY, PSLVERR});
    end
    n_cmp++; if (PRDATA !== '0) begin n_bad++; $display("FAIL tmo_prdata got %h want 0", PRDATA); end
    apb_end();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cfg_write();
    test_cfg_read();
    test_decode_err();
    test_tx_error();
    test_back_to_back();
    test_reset_mid_access();
`ifdef APB_UART_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
